pulse_param_loader: RTL and testbench

Configuration controller for the pulse sequencer. Parses a framed byte stream from the PC-link UART receiver into shadow copies of every sequencer parameter. It validates each frame with an XOR checksum and commits the shadow set to the active outputs only at a period boundary, so a running sequence never sees a half-updated parameter set. Sits between the UART receiver and the pulse generator, on the 50 MHz `clk` domain.

---
 rtl/pulse_param_loader.sv | 219 +++++++++++++++++++++
 tb/tb_pulse_param_loader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_param_loader.sv
// Pulse sequencer configuration loader: parses framed UART bytes into a shadow
// parameter set and commits it to the active outputs at a period boundary.
module pulse_param_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        period_start,
  output logic [31:0] per,
  output logic [15:0] p1wid,
  output logic [15:0] del,
  output logic [15:0] p2wid,
  output logic [7:0]  nut_w,
  output logic [15:0] nut_d,
  output logic [7:0]  cp,
  output logic [7:0]  p_bl,
  output logic [15:0] p_bl_off,
  output logic        bl,
  output logic        cfg_update,
  output logic        frame_ok,
  output logic [7:0]  err_cnt
);

  localparam int unsigned CNT_W = 20;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] ADDR_MAX = 8'd9;

  typedef struct packed {
    logic [31:0] per;
    logic [15:0] p1wid;
    logic [15:0] del;
    logic [15:0] p2wid;
    logic [7:0]  nut_w;
    logic [15:0] nut_d;
    logic [7:0]  cp;
    logic [7:0]  p_bl;
    logic [15:0] p_bl_off;
    logic        bl;
  } params_t;

  localparam params_t PARAMS_RST = '{
    per: 32'd20000, p1wid: 16'd30, del: 16'd200, p2wid: 16'd60,
    nut_w: 8'd0, nut_d: 16'd0, cp: 8'd1, p_bl: 8'd50,
    p_bl_off: 16'd100, bl: 1'b1
  };

  typedef enum logic [1:0] {IDLE, ADDR, DATA, CSUM} state_t;

  state_t           state, state_next;
  logic [3:0]       addr_q;
  logic [1:0]       len_m1_q;
  logic [1:0]       byte_cnt_q;
  logic [31:0]      asm_q;
  logic [7:0]       xor_q;
  logic [CNT_W-1:0] idle_cnt_q;
  params_t          shadow_q;
  params_t          active_q;
  params_t          shadow_wr_c;
  logic             pending_q;
  logic             frame_ok_q;
  logic             cfg_update_q;
  logic [7:0]       err_cnt_q;

  logic             timeout_c;
  logic             err_c;
  logic             load_addr_c;
  logic             data_c;
  logic             csum_ok_c;
  logic [1:0]       byte_idx_c;

  // Data bytes minus one for each register address.
  function automatic logic [1:0] len_m1_of(input logic [3:0] a);
    case (a)
      4'd0:                          len_m1_of = 2'd3;
      4'd1, 4'd2, 4'd3, 4'd5, 4'd8:  len_m1_of = 2'd1;
      default:                       len_m1_of = 2'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Frame parser next-state and control decode.
  always_comb begin
    state_next  = state;
    err_c       = 1'b0;
    load_addr_c = 1'b0;
    data_c      = 1'b0;
    csum_ok_c   = 1'b0;
    timeout_c   = (state != IDLE) && !rx_valid && (idle_cnt_q == TIMEOUT_LAST);
    case (state)
      IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) state_next = ADDR;
      end
      ADDR: begin
        if (timeout_c) begin
          err_c      = 1'b1;
          state_next = IDLE;
        end else if (rx_valid) begin
          if (rx_data <= ADDR_MAX) begin
            load_addr_c = 1'b1;
            state_next  = DATA;
          end else begin
            err_c      = 1'b1;
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (timeout_c) begin
          err_c      = 1'b1;
          state_next = IDLE;
        end else if (rx_valid) begin
          data_c = 1'b1;
          if (byte_cnt_q == 2'd0) state_next = CSUM;
        end
      end
      CSUM: begin
        if (timeout_c) begin
          err_c      = 1'b1;
          state_next = IDLE;
        end else if (rx_valid) begin
          if (rx_data == xor_q) csum_ok_c = 1'b1;
          else                  err_c     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign byte_idx_c = len_m1_q - byte_cnt_q;

  // Assembled value merged into the addressed shadow field.
  always_comb begin
    shadow_wr_c = shadow_q;
    case (addr_q)
      4'd0:    shadow_wr_c.per      = asm_q;
      4'd1:    shadow_wr_c.p1wid    = asm_q[15:0];
      4'd2:    shadow_wr_c.del      = asm_q[15:0];
      4'd3:    shadow_wr_c.p2wid    = asm_q[15:0];
      4'd4:    shadow_wr_c.nut_w    = asm_q[7:0];
      4'd5:    shadow_wr_c.nut_d    = asm_q[15:0];
      4'd6:    shadow_wr_c.cp       = asm_q[7:0];
      4'd7:    shadow_wr_c.p_bl     = asm_q[7:0];
      4'd8:    shadow_wr_c.p_bl_off = asm_q[15:0];
      4'd9:    shadow_wr_c.bl       = asm_q[0];
      default: shadow_wr_c = shadow_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      len_m1_q   <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      xor_q      <= '0;
      idle_cnt_q <= '0;
    end else begin
      if (load_addr_c) begin
        addr_q     <= rx_data[3:0];
        len_m1_q   <= len_m1_of(rx_data[3:0]);
        byte_cnt_q <= len_m1_of(rx_data[3:0]);
        asm_q      <= '0;
        xor_q      <= rx_data;
      end else if (data_c) begin
        asm_q[{byte_idx_c, 3'b000} +: 8] <= rx_data;
        xor_q      <= xor_q ^ rx_data;
        byte_cnt_q <= byte_cnt_q - 2'd1;
      end
      if (state == IDLE || rx_valid || timeout_c) idle_cnt_q <= '0;
      else                                        idle_cnt_q <= idle_cnt_q + CNT_W'(1);
    end
  end

  // Shadow/active registers; commit reads the shadow before any same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q     <= PARAMS_RST;
      active_q     <= PARAMS_RST;
      pending_q    <= 1'b0;
      cfg_update_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      cfg_update_q <= period_start && pending_q;
      frame_ok_q   <= csum_ok_c;
      if (period_start && pending_q) active_q <= shadow_q;
      if (csum_ok_c) begin
        shadow_q  <= shadow_wr_c;
        pending_q <= 1'b1;
      end else if (period_start) begin
        pending_q <= 1'b0;
      end
      if (err_c && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign per        = active_q.per;
  assign p1wid      = active_q.p1wid;
  assign del        = active_q.del;
  assign p2wid      = active_q.p2wid;
  assign nut_w      = active_q.nut_w;
  assign nut_d      = active_q.nut_d;
  assign cp         = active_q.cp;
  assign p_bl       = active_q.p_bl;
  assign p_bl_off   = active_q.p_bl_off;
  assign bl         = active_q.bl;
  assign cfg_update = cfg_update_q;
  assign frame_ok   = frame_ok_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_pulse_param_loader.sv
// Directed bench for pulse_param_loader: reference model of shadow/active sets
// with queued expected commits and frame acknowledgements.
module tb_pulse_param_loader;

  localparam int unsigned T    = 64;
  localparam logic [7:0]  SYNC = 8'hA5;

  typedef struct packed {
    logic [31:0] per;
    logic [15:0] p1wid;
    logic [15:0] del;
    logic [15:0] p2wid;
    logic [7:0]  nut_w;
    logic [15:0] nut_d;
    logic [7:0]  cp;
    logic [7:0]  p_bl;
    logic [15:0] p_bl_off;
    logic        bl;
  } cfg_t;

  logic        clk = 1'b0;
  logic        reset, rx_valid, period_start;
  logic [7:0]  rx_data;
  logic [31:0] per;
  logic [15:0] p1wid, del, p2wid, nut_d, p_bl_off;
  logic [7:0]  nut_w, cp, p_bl, err_cnt;
  logic        bl, cfg_update, frame_ok;

  cfg_t model_shadow, model_active;
  logic model_pending;
  int   exp_err;
  cfg_t exp_q[$];
  int   ok_q[$];
  int   errors = 0;
  int   checks = 0;

  pulse_param_loader #(.TIMEOUT_CYCLES(T), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .period_start(period_start), .per(per), .p1wid(p1wid), .del(del),
    .p2wid(p2wid), .nut_w(nut_w), .nut_d(nut_d), .cp(cp), .p_bl(p_bl),
    .p_bl_off(p_bl_off), .bl(bl), .cfg_update(cfg_update),
    .frame_ok(frame_ok), .err_cnt(err_cnt)
  );

  always #10 clk = ~clk;

  function automatic cfg_t defaults();
    return '{per: 32'd20000, p1wid: 16'd30, del: 16'd200, p2wid: 16'd60,
             nut_w: 8'd0, nut_d: 16'd0, cp: 8'd1, p_bl: 8'd50,
             p_bl_off: 16'd100, bl: 1'b1};
  endfunction

  function automatic cfg_t observed();
    return '{per: per, p1wid: p1wid, del: del, p2wid: p2wid, nut_w: nut_w,
             nut_d: nut_d, cp: cp, p_bl: p_bl, p_bl_off: p_bl_off, bl: bl};
  endfunction

  function automatic int len_of(input int a);
    case (a)
      0:                 return 4;
      1, 2, 3, 5, 8:     return 2;
      default:           return 1;
    endcase
  endfunction

  function automatic cfg_t apply(input cfg_t s, input int a, input logic [31:0] v);
    cfg_t r = s;
    case (a)
      0: r.per      = v;
      1: r.p1wid    = v[15:0];
      2: r.del      = v[15:0];
      3: r.p2wid    = v[15:0];
      4: r.nut_w    = v[7:0];
      5: r.nut_d    = v[15:0];
      6: r.cp       = v[7:0];
      7: r.p_bl     = v[7:0];
      8: r.p_bl_off = v[15:0];
      default: r.bl = v[0];
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bump_err();
    if (exp_err < 255) exp_err++;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ps);
    rx_data      = b;
    rx_valid     = 1'b1;
    period_start = ps;
    tick();
    rx_valid     = 1'b0;
    period_start = 1'b0;
  endtask

  task automatic model_commit();
    if (model_pending) begin
      exp_q.push_back(model_shadow);
      model_active  = model_shadow;
      model_pending = 1'b0;
    end
  endtask

  // Full frame; optional checksum corruption, period_start on the CSUM byte, idle gaps.
  task automatic send_frame(input int a, input logic [31:0] v, input bit bad,
                            input bit ps_last, input int gap);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'(a);
    send_byte(SYNC, 1'b0);
    repeat (gap) tick();
    send_byte(8'(a), 1'b0);
    repeat (gap) tick();
    for (int i = 0; i < len_of(a); i++) begin
      b  = v[8*i +: 8];
      cs = cs ^ b;
      send_byte(b, 1'b0);
      repeat (gap) tick();
    end
    if (bad) cs = cs ^ 8'h01;
    if (ps_last) model_commit();
    if (!bad) begin
      model_shadow  = apply(model_shadow, a, v);
      model_pending = 1'b1;
      ok_q.push_back(a);
    end else begin
      bump_err();
    end
    send_byte(cs, ps_last);
    chk("frame_ok_timing", 160'(frame_ok), 160'(!bad));
  endtask

  task automatic pulse();
    logic had;
    had = model_pending;
    model_commit();
    period_start = 1'b1;
    tick();
    period_start = 1'b0;
    chk("cfg_update", 160'(cfg_update), 160'(had));
    chk("active_set", 160'(observed()), 160'(model_active));
  endtask

  task automatic model_reset();
    model_shadow  = defaults();
    model_active  = defaults();
    model_pending = 1'b0;
    exp_err       = 0;
  endtask

  // Scoreboard side: every DUT strobe consumes one expected entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (cfg_update) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_cfg_update observed=1 expected=0");
        end
        if (exp_q.size() > 0) begin
          cfg_t e;
          e = exp_q.pop_front();
          chk("commit_set", 160'(observed()), 160'(e));
        end
      end
      if (frame_ok) begin
        checks++;
        assert (ok_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_frame_ok observed=1 expected=0");
        end
        if (ok_q.size() > 0) void'(ok_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; period_start = 1'b0;
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_outputs", 160'(observed()), 160'(defaults()));
    chk("reset_err_cnt", 160'(err_cnt), 160'(0));
    chk("reset_frame_ok", 160'(frame_ok), 160'(0));
    pulse();

    // Stray bytes while idle are dropped silently.
    send_byte(8'h00, 1'b0); send_byte(8'h5A, 1'b0); send_byte(8'h3C, 1'b0);
    tick();
    chk("idle_junk_err", 160'(err_cnt), 160'(exp_err));

    send_frame(0, 32'd40000, 1'b0, 1'b0, 0);
    chk("per_before_commit", 160'(per), 160'(20000));
    repeat (5) tick();
    chk("per_still_old", 160'(per), 160'(20000));
    pulse();
    chk("per_committed", 160'(per), 160'(40000));
    tick();
    chk("cfg_update_one_cycle", 160'(cfg_update), 160'(0));

    send_frame(1, 32'h0000002D, 1'b1, 1'b0, 0);
    chk("bad_csum_err", 160'(err_cnt), 160'(exp_err));
    pulse();
    chk("bad_csum_p1wid", 160'(p1wid), 160'(30));

    send_byte(SYNC, 1'b0); send_byte(8'h0C, 1'b0); bump_err();
    tick();
    chk("bad_addr_err", 160'(err_cnt), 160'(exp_err));

    send_byte(SYNC, 1'b0); send_byte(8'h06, 1'b0);
    repeat (T - 1) tick();
    chk("timeout_not_yet", 160'(err_cnt), 160'(exp_err));
    tick(); bump_err();
    chk("timeout_err", 160'(err_cnt), 160'(exp_err));
    send_frame(6, 32'd3, 1'b0, 1'b0, 0);
    pulse();
    chk("cp_after_timeout", 160'(cp), 160'(3));

    send_frame(2, 32'h00000777, 1'b0, 1'b0, T - 1);
    chk("gap_no_err", 160'(err_cnt), 160'(exp_err));
    pulse();

    send_frame(3, 32'h00001234, 1'b0, 1'b1, 0);
    chk("sim_no_update", 160'(cfg_update), 160'(0));
    chk("sim_p2wid_old", 160'(p2wid), 160'(60));
    tick();
    pulse();
    chk("sim_p2wid_new", 160'(p2wid), 160'(16'h1234));

    send_frame(4, 32'h00000011, 1'b0, 1'b0, 0);
    send_frame(5, 32'h0000A5A5, 1'b0, 1'b1, 0);
    chk("sim_pending_nut_d", 160'(nut_d), 160'(0));
    send_frame(7, 32'h00000021, 1'b0, 1'b0, 0);
    send_frame(8, 32'h0000BEEF, 1'b0, 1'b0, 0);
    send_frame(9, 32'h000000FE, 1'b0, 1'b0, 0);
    pulse();
    chk("accum_bl", 160'(bl), 160'(0));

    repeat (300) begin
      send_byte(SYNC, 1'b0); send_byte(8'h0C, 1'b0); bump_err();
    end
    tick();
    chk("err_saturate", 160'(err_cnt), 160'(255));

    send_byte(SYNC, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    chk("midreset_outputs", 160'(observed()), 160'(defaults()));
    chk("midreset_err_cnt", 160'(err_cnt), 160'(0));
    send_frame(0, 32'h00012345, 1'b0, 1'b0, 0);
    pulse();
    chk("fresh_frame_per", 160'(per), 160'(32'h00012345));
    chk("fresh_err_cnt", 160'(err_cnt), 160'(0));

    repeat (3) tick();
    chk("commits_drained", 160'(exp_q.size()), 160'(0));
    chk("frame_oks_drained", 160'(ok_q.size()), 160'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
